// File: rtl/fmap_stream_reader.sv
// rtl/fmap_stream_reader.sv - raster-order feature-map reader from 1R1W SRAM to a valid/ready stream
//
// Purpose: on an accepted start, reads FMAP_H x FMAP_W pixels from base_addr
// upward (wrapping modulo 2^ADDR_WIDTH) and streams them out with row/frame
// markers. A 2-entry FIFO covers the 1-cycle SRAM latency and consumer stalls.
//
// Ports:
//   clk, rst_n       clock (posedge), asynchronous active-low reset
//   start, base_addr frame request and start address (sampled in IDLE only)
//   busy, done       frame in progress / one-cycle completion pulse
//   sram_*           SRAM chip select, read request, address, read data
//   out_*            pixel stream: valid/ready, data, row_last, frame_last
module fmap_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int FMAP_W     = 32,
    parameter int FMAP_H     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_csen,
    output logic                  sram_rd_en,
    output logic [ADDR_WIDTH-1:0] sram_rd_addr,
    input  logic [DATA_WIDTH-1:0] sram_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_row_last,
    output logic                  out_frame_last
);

    localparam int COL_W = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
    localparam int ROW_W = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;
    localparam int ENT_W = DATA_WIDTH + 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   inflight_q, inflight_d;
    logic                   pend_rl_q, pend_rl_d;
    logic                   pend_fl_q, pend_fl_d;
    logic [ENT_W-1:0]       ent_q [2];
    logic [ENT_W-1:0]       ent_d [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;

    logic hs;
    logic last_col;
    logic last_row;
    logic issue;

    assign hs       = out_valid & out_ready;
    assign last_col = (col_q == COL_W'(FMAP_W - 1));
    assign last_row = (row_q == ROW_W'(FMAP_H - 1));
    // A pop in this cycle frees a slot before the new read's data can land,
    // so a handshake always grants a credit even when the buffer looks full.
    assign issue    = (state_q == S_RUN) &&
                      ((({1'b0, count_q} + {2'b0, inflight_q}) < 3'd2) || hs);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (issue && last_col && last_row) state_d = S_DRAIN;
            // The frame_last pixel is the final one; its handshake empties
            // the buffer with nothing left in flight.
            S_DRAIN: if (hs && out_frame_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        sram_csen      = (state_q != S_IDLE);
        sram_rd_en     = issue;
        sram_rd_addr   = issue ? addr_q : '0;
        out_valid      = (count_q != 2'd0);
        {out_frame_last, out_row_last, out_data} = ent_q[rd_ptr_q];
    end

    // Datapath: scan counters, in-flight tracking, output FIFO
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        inflight_d = issue;
        pend_rl_d = issue & last_col;
        pend_fl_d = issue & last_col & last_row;
        ent_d     = ent_q;
        wr_ptr_d  = wr_ptr_q ^ inflight_q;
        rd_ptr_d  = rd_ptr_q ^ hs;
        count_d   = count_q + {1'b0, inflight_q} - {1'b0, hs};

        if (state_q == S_IDLE && start) begin
            addr_d = base_addr;
            col_d  = '0;
            row_d  = '0;
        end

        if (issue) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        // Data for last cycle's read is on sram_rd_data now.
        if (inflight_q) begin
            ent_d[wr_ptr_q] = {pend_fl_q, pend_rl_q, sram_rd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            pend_rl_q  <= 1'b0;
            pend_fl_q  <= 1'b0;
            ent_q[0]   <= '0;
            ent_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            pend_rl_q  <= pend_rl_d;
            pend_fl_q  <= pend_fl_d;
            ent_q[0]   <= ent_d[0];
            ent_q[1]   <= ent_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_fmap_stream_reader.sv
// tb/tb_fmap_stream_reader.sv - self-checking bench for fmap_stream_reader
module tb_fmap_stream_reader;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, sram_csen, sram_rd_en;
    logic [AW-1:0] sram_rd_addr;
    logic [DW-1:0] sram_rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_row_last, out_frame_last;

    fmap_stream_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FMAP_W(W), .FMAP_H(H)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .sram_csen(sram_csen), .sram_rd_en(sram_rd_en),
        .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row_last(out_row_last), .out_frame_last(out_frame_last)
    );

    always #5 clk = ~clk;

    // SRAM model: mem[a] = a - 15, so base 0x010 holds 1, 2, 3, ...
    logic [DW-1:0] mem [1024];
    initial for (int i = 0; i < 1024; i++) mem[i] = DW'((i - 15) & 255);
    always @(posedge clk) if (sram_csen && sram_rd_en) sram_rd_data <= mem[sram_rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: logs reads, handshakes and done pulses; checks credit bound
    logic [AW-1:0] rd_q[$];
    int            rd_cyc_q[$];
    logic [DW+1:0] px_q[$];
    int            hs_cyc_q[$];
    int            done_cnt = 0, done_cyc = 0, credit_err = 0, outstanding = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            if (outstanding > 2) credit_err++;
            if (sram_rd_en) begin
                rd_q.push_back(sram_rd_addr);
                rd_cyc_q.push_back(cyc);
                outstanding++;
            end
            if (out_valid && out_ready) begin
                px_q.push_back({out_frame_last, out_row_last, out_data});
                hs_cyc_q.push_back(cyc);
                outstanding--;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    int n_checks = 0, n_err = 0;

    function automatic void chk(string name, int unsigned act, int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    int rb, pb, db, cb, start_cyc;
    logic [1:0] rmode = 2'd0;

    task automatic snap();
        rb = rd_q.size(); pb = px_q.size(); db = done_cnt; cb = credit_err;
    endtask

    task automatic drive_ready();
        case (rmode)
            2'd0:    out_ready = 1'b1;
            2'd1:    out_ready = cyc[0];
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        @(posedge clk); #1;
        drive_ready(); base_addr = b; start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        drive_ready(); start = 1'b0; base_addr = 10'h155;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == db && n < 300) begin
            @(posedge clk); #1;
            drive_ready();
            n++;
        end
        chk("done_pulse_count", done_cnt - db, 1);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic check_frame(input logic [AW-1:0] b, input logic [7:0] exp_first,
                               input logic [AW-1:0] exp_last, input bit timed);
        logic [DW+1:0] exp_px;
        chk("read_count", rd_q.size() - rb, N);
        chk("pixel_count", px_q.size() - pb, N);
        for (int k = 0; k < N; k++) begin
            if (rb + k < rd_q.size())
                chk($sformatf("rd_addr[%0d]", k), rd_q[rb + k], AW'(b + k));
            if (pb + k < px_q.size()) begin
                exp_px = {k == N - 1, (k % W) == W - 1, DW'(((int'(b) + k) % 1024) - 15)};
                chk($sformatf("pixel[%0d]", k), px_q[pb + k], exp_px);
            end
        end
        if (px_q.size() > pb) chk("first_data", px_q[pb][DW-1:0], exp_first);
        if (rd_q.size() >= rb + N) chk("last_addr", rd_q[rb + N - 1], exp_last);
        chk("credit_bound", credit_err - cb, 0);
        if (px_q.size() >= pb + N) begin
            chk("done_after_last", done_cyc - hs_cyc_q[pb + N - 1], 1);
            if (timed) begin
                chk("first_valid_latency", hs_cyc_q[pb] - start_cyc, 3);
                chk("stream_span", hs_cyc_q[pb + N - 1] - hs_cyc_q[pb], N - 1);
            end
        end
        if (timed && rd_q.size() >= rb + N)
            chk("read_span", rd_cyc_q[rb + N - 1] - rd_cyc_q[rb], N - 1);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [1:0]    mode;
        logic [7:0]    exp_first;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rbb;
        vecs[0] = '{base: 10'h010, mode: 2'd0, exp_first: 8'h01, exp_last: 10'h01B};
        vecs[1] = '{base: 10'h010, mode: 2'd1, exp_first: 8'h01, exp_last: 10'h01B};
        vecs[2] = '{base: 10'h3FE, mode: 2'd0, exp_first: 8'hEF, exp_last: 10'h009};
        vecs[3] = '{base: 10'h100, mode: 2'd1, exp_first: 8'hF1, exp_last: 10'h10B};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, sram_csen, sram_rd_en, sram_rd_addr, out_valid,
                              out_data, out_row_last, out_frame_last}, 0);
        rst_n = 1'b1;

        // Table-driven frames: streaming, toggling backpressure, address wrap
        for (int i = 0; i < 4; i++) begin
            rmode = vecs[i].mode;
            snap();
            do_start(vecs[i].base);
            wait_done();
            check_frame(vecs[i].base, vecs[i].exp_first, vecs[i].exp_last, vecs[i].mode == 2'd0);
        end

        // Stalled consumer: two reads only, head held stable
        rmode = 2'd2;
        snap();
        do_start(10'h010);
        @(posedge clk); #1;
        @(posedge clk); #1;
        repeat (20) begin
            @(negedge clk);
            chk("stall_head", {out_valid, out_data}, 9'h101);
        end
        chk("stall_reads", rd_q.size() - rb, 2);
        if (rd_q.size() >= rb + 2) begin
            chk("stall_rd0", rd_q[rb], 10'h010);
            chk("stall_rd1", rd_q[rb + 1], 10'h011);
        end
        rmode = 2'd0;
        @(posedge clk); #1;
        drive_ready();
        wait_done();
        check_frame(10'h010, 8'h01, 10'h01B, 1'b0);

        // Start while busy is ignored
        rmode = 2'd0;
        snap();
        do_start(10'h010);
        repeat (3) begin @(posedge clk); #1; end
        base_addr = 10'h100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        check_frame(10'h010, 8'h01, 10'h01B, 1'b1);

        // New frame two cycles after done uses its own base
        snap();
        do_start(10'h100);
        wait_done();
        check_frame(10'h100, 8'hF1, 10'h10B, 1'b1);

        // Start in the DONE cycle is ignored
        snap();
        do_start(10'h010);
        n = 0;
        while (!done && n < 300) begin @(posedge clk); #1; n++; end
        chk("done_seen_live", done, 1);
        base_addr = 10'h200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_done_busy", busy, 0);
        rbb = rd_q.size();
        repeat (5) begin @(posedge clk); #1; end
        chk("start_in_done_reads", rd_q.size() - rbb, 0);
        check_frame(10'h010, 8'h01, 10'h01B, 1'b1);

        // Reset mid-frame after pixel 5
        snap();
        do_start(10'h010);
        n = 0;
        while (px_q.size() - pb < 5 && n < 100) begin @(posedge clk); #1; n++; end
        chk("reached_pixel5", px_q.size() - pb, 5);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_outputs", {busy, done, sram_csen, sram_rd_en, sram_rd_addr, out_valid,
                                  out_data, out_row_last, out_frame_last}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        db = done_cnt;
        repeat (15) begin @(posedge clk); #1; end
        chk("no_done_after_reset", done_cnt - db, 0);
        chk("idle_after_reset", {busy, out_valid}, 0);
        snap();
        do_start(10'h010);
        wait_done();
        check_frame(10'h010, 8'h01, 10'h01B, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/fmap_stream_reader.md
Name: fmap_stream_reader

Overview:
- Downstream consumer of the 1R1W feature-map SRAM (synchronous read, 1-cycle latency, active-high chip select).
- On a start pulse it scans one FMAP_H x FMAP_W feature map in raster order from a programmable base address.
- It streams the pixels to the next stage (conv window / MAC array) over a valid/ready interface.
- A 2-entry output buffer absorbs the SRAM read latency and backpressure, so no pixel is lost or duplicated.

Parameters:
- DATA_WIDTH, 8: pixel width; must match the SRAM data width.
- ADDR_WIDTH, 10: SRAM address width.
- FMAP_W, 32: pixels per row (>=1).
- FMAP_H, 32: rows per frame (>=1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame start request; ignored while busy=1.
- base_addr  in  ADDR_WIDTH  address of pixel (0,0); sampled on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last pixel handshake.
- sram_csen  out  1  SRAM chip select; high whenever busy.
- sram_rd_en  out  1  read request.
- sram_rd_addr  out  ADDR_WIDTH  read address.
- sram_rd_data  in  DATA_WIDTH  SRAM read data, valid the cycle after sram_rd_en.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts; handshake = out_valid & out_ready.
- out_data  out  DATA_WIDTH  pixel value.
- out_row_last  out  1  pixel is the last in its row (col == FMAP_W-1).
- out_frame_last  out  1  pixel is the last in the frame.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters and buffer empty. Reset mid-frame aborts immediately and discards the frame; no done pulse.
- FSM states and transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN in the cycle the last read (index FMAP_W*FMAP_H-1) is issued.
  - DRAIN -> DONE when the buffer is empty, nothing is in flight, and the last handshake has occurred.
  - DONE -> IDLE unconditionally after 1 cycle; done=1 only in DONE.
  - busy=1 in RUN, DRAIN and DONE.
- Addressing: read k uses sram_rd_addr = base_addr + k, truncated modulo 2^ADDR_WIDTH (wraps, no error). Row and column counters track the issued pixel; row_last and frame_last flags travel with each read.
- Read latency: read issued in cycle c is captured into the buffer at the end of cycle c+1 and is visible on out_valid in cycle c+2.
- Read issue (credit rule): issue in cycle c only in RUN and only if (occupancy + inflight < 2) or a handshake occurs in c. inflight = 1 if a read was issued in c-1.
- Output stage:
  - The buffer is a 2-entry FIFO of {data, row_last, frame_last}.
  - out_valid = buffer not empty; out_* fields show the head entry.
  - Head is stable while out_valid=1 and out_ready=0.
- Throughput: with out_ready held at 1, one pixel per cycle; first out_valid appears 3 cycles after the start edge (IDLE->RUN edge, issue, capture).
- Simultaneous events: capture and pop in the same cycle are both applied; occupancy is unchanged.
- Start handling: start during busy is ignored and base_addr is not resampled. Start in the DONE cycle is also ignored.

Test Plan:
- Streaming read: FMAP_W=4, FMAP_H=3, base 0x010, mem[0x010+k]=k+1, out_ready=1. Expect:
  - reads at 0x010..0x01B on consecutive cycles;
  - out_data 1..12 on 12 consecutive cycles;
  - row_last on pixels 4, 8, 12; frame_last on 12 only;
  - done pulse the cycle after pixel 12, then busy=0.
- Stalled consumer: out_ready=0 from start. Expect exactly 2 reads issued (0x010, 0x011), out_valid=1 with out_data=1 held stable for 20 cycles. Release out_ready: remaining 10 reads resume and all 12 pixels arrive in order.
- Toggling backpressure: out_ready pattern 1,0,1,0,... Expect 12 in-order pixels with no duplicates and occupancy+inflight never above 2.
- Address wrap: ADDR_WIDTH=10, base 0x3FE, 4x3 frame. Expect addresses 0x3FE, 0x3FF, 0x000..0x009.
- Start while busy: second start with base 0x100 mid-frame is ignored; the frame completes from 0x010. A start 2 cycles after done begins a new frame from its own base_addr.
- Reset mid-frame: rst_n low for 1 cycle after pixel 5. Expect all outputs 0 and no done pulse. A subsequent start streams a full frame correctly.
